xor_stream_parity: RTL and testbench

Parametrised streaming successor to the single-bit XOR gate. Folds a packet of WIDTH-bit words into one WIDTH-bit XOR signature, a reduction parity bit and a beat count. Uses valid/ready handshakes on both sides. Sits on datapath ingress as a lightweight integrity checker ahead of packet buffering.

---
 rtl/xor_stream_parity.sv | 191 +++++++++++++++++++
 tb/tb_xor_stream_parity.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/xor_stream_parity.sv
// xor_stream_parity
// Streaming packet integrity folder. Accepts a packet of WIDTH-bit words on a
// valid/ready input, folds them into one XOR signature, a reduction parity bit
// (even or odd sense) and a saturating beat count, and presents the result on
// a valid/ready output until consumed.
//
// Optional feature macro: XOR_STREAM_ERR_EN
//   When defined, adds per-beat expected parity checking (in_parity) and a
//   sticky per-packet error flag (out_err).
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    input beat valid
//   in_ready    block can accept a beat (registered, depends on state only)
//   in_data     input word
//   in_last     last beat of the packet
//   out_valid   packet result valid
//   out_ready   downstream accepts the result
//   out_xor     XOR of all packet words
//   out_parity  reduction parity of out_xor, XOR ODD
//   out_beats   number of beats in the packet, saturating
//   in_parity   per-beat expected parity      (XOR_STREAM_ERR_EN only)
//   out_err     parity mismatch seen in packet (XOR_STREAM_ERR_EN only)
module xor_stream_parity #(
  parameter int WIDTH = 8,
  parameter bit ODD   = 1'b0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_xor,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_beats
`ifdef XOR_STREAM_ERR_EN
  ,
  input  logic             in_parity,
  output logic             out_err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic red_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  state_t             state_r;
  logic               in_ready_r;
  logic [WIDTH-1:0]   acc_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               out_valid_r;
  logic [WIDTH-1:0]   out_xor_r;
  logic               out_parity_r;
  logic [CNT_W-1:0]   out_beats_r;

  logic               accept_s;
  logic               consume_s;
  logic               first_s;
  logic [WIDTH-1:0]   acc_nxt_s;
  logic [CNT_W-1:0]   cnt_nxt_s;

  assign accept_s  = in_valid && in_ready_r;
  assign consume_s = out_valid_r && out_ready;
  assign first_s   = (state_r == IDLE);

  // Next accumulator values for an accepted beat; the first beat loads rather than folds.
  always_comb begin
    acc_nxt_s = acc_r;
    cnt_nxt_s = cnt_r;
    if (first_s) begin
      acc_nxt_s = in_data;
      cnt_nxt_s = CNT_W'(1);
    end else begin
      acc_nxt_s = acc_r ^ in_data;
      cnt_nxt_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_W'(1);
    end
  end

  // Packet FSM with accumulators and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      in_ready_r   <= 1'b1;
      acc_r        <= '0;
      cnt_r        <= '0;
      out_valid_r  <= 1'b0;
      out_xor_r    <= '0;
      out_parity_r <= ODD;
      out_beats_r  <= '0;
    end else begin
      case (state_r)
        IDLE, ACCUM: begin
          if (accept_s) begin
            acc_r <= acc_nxt_s;
            cnt_r <= cnt_nxt_s;
            if (in_last) begin
              state_r      <= HOLD;
              in_ready_r   <= 1'b0;
              out_valid_r  <= 1'b1;
              out_xor_r    <= acc_nxt_s;
              out_parity_r <= red_parity(acc_nxt_s) ^ ODD;
              out_beats_r  <= cnt_nxt_s;
            end else begin
              state_r <= ACCUM;
            end
          end else begin
            state_r <= state_r;
          end
        end
        HOLD: begin
          if (consume_s) begin
            state_r      <= IDLE;
            in_ready_r   <= 1'b1;
            acc_r        <= '0;
            cnt_r        <= '0;
            out_valid_r  <= 1'b0;
            out_xor_r    <= '0;
            out_parity_r <= ODD;
            out_beats_r  <= '0;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_xor    = out_xor_r;
  assign out_parity = out_parity_r;
  assign out_beats  = out_beats_r;

`ifdef XOR_STREAM_ERR_EN
  logic err_r;
  logic out_err_r;
  logic err_nxt_s;

  // Sticky error update for an accepted beat; the first beat starts a fresh flag.
  always_comb begin
    err_nxt_s = err_r;
    if (first_s) begin
      err_nxt_s = ((red_parity(in_data) ^ ODD) != in_parity);
    end else begin
      err_nxt_s = err_r | ((red_parity(in_data) ^ ODD) != in_parity);
    end
  end

  // Error flag tracking alongside the packet FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r     <= 1'b0;
      out_err_r <= 1'b0;
    end else if ((state_r != HOLD) && accept_s) begin
      err_r <= err_nxt_s;
      if (in_last) begin
        out_err_r <= err_nxt_s;
      end else begin
        out_err_r <= out_err_r;
      end
    end else if ((state_r == HOLD) && consume_s) begin
      err_r     <= 1'b0;
      out_err_r <= 1'b0;
    end else begin
      err_r     <= err_r;
      out_err_r <= out_err_r;
    end
  end

  assign out_err = out_err_r;
`endif

endmodule

// File: tb/tb_xor_stream_parity.sv
module tb_xor_stream_parity;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance A: WIDTH=8, ODD=0, CNT_W=16
  logic       a_in_valid = 1'b0;
  logic       a_in_ready;
  logic [7:0] a_in_data = 8'h00;
  logic       a_in_last = 1'b0;
  logic       a_out_valid;
  logic       a_out_ready = 1'b0;
  logic [7:0] a_out_xor;
  logic       a_out_parity;
  logic [15:0] a_out_beats;
  logic       a_in_parity = 1'b0;
  logic       a_out_err;

  // Instance B: WIDTH=8, ODD=0, CNT_W=2 (saturation)
  logic       b_in_valid = 1'b0;
  logic       b_in_ready;
  logic [7:0] b_in_data = 8'h00;
  logic       b_in_last = 1'b0;
  logic       b_out_valid;
  logic       b_out_ready = 1'b0;
  logic [7:0] b_out_xor;
  logic       b_out_parity;
  logic [1:0] b_out_beats;
  logic       b_in_parity = 1'b0;
  logic       b_out_err;

  int errors = 0;
  int checks = 0;

  xor_stream_parity #(.WIDTH(8), .ODD(1'b0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_xor(a_out_xor),
    .out_parity(a_out_parity), .out_beats(a_out_beats)
`ifdef XOR_STREAM_ERR_EN
    , .in_parity(a_in_parity), .out_err(a_out_err)
`endif
  );

  xor_stream_parity #(.WIDTH(8), .ODD(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_xor(b_out_xor),
    .out_parity(b_out_parity), .out_beats(b_out_beats)
`ifdef XOR_STREAM_ERR_EN
    , .in_parity(b_in_parity), .out_err(b_out_err)
`endif
  );

`ifndef XOR_STREAM_ERR_EN
  assign a_out_err = 1'b0;
  assign b_out_err = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        ordy;
    logic        ev;
    logic        er;
    logic [7:0]  ex;
    logic        ep;
    logic [15:0] eb;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [7:0] d, input logic l, input logic ordy, input logic par);
    a_in_valid  = v;
    a_in_data   = d;
    a_in_last   = l;
    a_out_ready = ordy;
    a_in_parity = par;
  endtask

  task automatic check_a(input int idx, input logic ev, input logic er, input logic [7:0] ex,
                         input logic ep, input logic [15:0] eb);
    chk("a_out_valid", idx, 32'(a_out_valid), 32'(ev));
    chk("a_in_ready", idx, 32'(a_in_ready), 32'(er));
    chk("a_out_xor", idx, 32'(a_out_xor), 32'(ex));
    chk("a_out_parity", idx, 32'(a_out_parity), 32'(ep));
    chk("a_out_beats", idx, 32'(a_out_beats), 32'(eb));
  endtask

  initial begin
    // single beat A5
    tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 16'd1};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 16'd0};
    // 01, 02, gap (ignored data/last), 04
    tbl[2]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 16'd0};
    tbl[4]  = '{1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 16'd0};
    tbl[5]  = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 1'b0, 8'h07, 1'b1, 16'd3};
    tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 16'd0};
    // backpressure: packet 10,20 then five held cycles with changing input
    tbl[7]  = '{1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 16'd0};
    tbl[8]  = '{1'b1, 8'h20, 1'b1, 1'b0, 1'b1, 1'b0, 8'h30, 1'b0, 16'd2};
    tbl[9]  = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 8'h30, 1'b0, 16'd2};
    tbl[10] = '{1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 1'b0, 8'h30, 1'b0, 16'd2};
    tbl[11] = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0, 8'h30, 1'b0, 16'd2};
    tbl[12] = '{1'b1, 8'h88, 1'b1, 1'b0, 1'b1, 1'b0, 8'h30, 1'b0, 16'd2};
    tbl[13] = '{1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 1'b0, 8'h30, 1'b0, 16'd2};
    // consumed; AA not accepted (in_ready was 0)
    tbl[14] = '{1'b1, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 16'd0};
    // new packet starts cleanly
    tbl[15] = '{1'b1, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 8'hC3, 1'b0, 16'd1};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 16'd0};

    // reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_a(100, 1'b0, 1'b1, 8'h00, 1'b0, 16'd0);
    chk("a_out_err_reset", 100, 32'(a_out_err), 32'd0);
    chk("b_in_ready_reset", 100, 32'(b_in_ready), 32'd1);
    chk("b_out_valid_reset", 100, 32'(b_out_valid), 32'd0);

    // table-driven main sequence on instance A
    for (int i = 0; i < 17; i++) begin
      drive_a(tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].ordy, ^tbl[i].d);
      step();
      check_a(i, tbl[i].ev, tbl[i].er, tbl[i].ex, tbl[i].ep, tbl[i].eb);
      chk("a_out_err", i, 32'(a_out_err), 32'd0);
    end

    // reset mid-packet: FF, 0F then reset; aborted packet yields nothing
    drive_a(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0);
    step();
    drive_a(1'b1, 8'h0F, 1'b0, 1'b1, 1'b0);
    step();
    drive_a(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_a(200, 1'b0, 1'b1, 8'h00, 1'b0, 16'd0);
    step();
    check_a(201, 1'b0, 1'b1, 8'h00, 1'b0, 16'd0);
    drive_a(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    step();
    check_a(202, 1'b1, 1'b0, 8'h3C, 1'b0, 16'd1);
    drive_a(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step();
    check_a(203, 1'b0, 1'b1, 8'h00, 1'b0, 16'd0);

    // reset while holding a result discards it
    drive_a(1'b1, 8'h81, 1'b1, 1'b0, 1'b0);
    step();
    check_a(210, 1'b1, 1'b0, 8'h81, 1'b0, 16'd1);
    drive_a(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_a(211, 1'b0, 1'b1, 8'h00, 1'b0, 16'd0);

    // saturation on instance B: six beats of 0x11, CNT_W=2
    for (int i = 0; i < 6; i++) begin
      b_in_valid = 1'b1;
      b_in_data  = 8'h11;
      b_in_last  = (i == 5);
      b_out_ready = 1'b0;
      step();
      chk("b_out_valid_mid", i, 32'(b_out_valid), (i == 5) ? 32'd1 : 32'd0);
    end
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
    chk("b_out_beats_sat", 300, 32'(b_out_beats), 32'd3);
    chk("b_out_xor_sat", 300, 32'(b_out_xor), 32'h00);
    chk("b_out_parity_sat", 300, 32'(b_out_parity), 32'd0);
    chk("b_in_ready_hold", 300, 32'(b_in_ready), 32'd0);
    b_out_ready = 1'b1;
    step();
    chk("b_out_valid_cons", 301, 32'(b_out_valid), 32'd0);
    chk("b_in_ready_cons", 301, 32'(b_in_ready), 32'd1);
    b_out_ready = 1'b0;

`ifdef XOR_STREAM_ERR_EN
    // parity checking: 03 (par 0 matches), 01 (par 0 mismatches)
    drive_a(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    step();
    drive_a(1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    step();
    check_a(400, 1'b1, 1'b0, 8'h02, 1'b1, 16'd2);
    chk("a_out_err_set", 400, 32'(a_out_err), 32'd1);
    drive_a(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step();
    chk("a_out_err_clr", 401, 32'(a_out_err), 32'd0);
    drive_a(1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
    step();
    check_a(402, 1'b1, 1'b0, 8'h01, 1'b1, 16'd1);
    chk("a_out_err_ok", 402, 32'(a_out_err), 32'd0);
    drive_a(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    step();
    check_a(403, 1'b0, 1'b1, 8'h00, 1'b0, 16'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
